// File: rtl/rst_seq_gen.sv
// rst_seq_gen: staged active-low reset generator.
// Holds every stage in reset for HOLD_CYC cycles, then releases the stages in
// index order, GAP_CYC cycles apart. A sequence runs after rst falls or when
// req is sampled high. The optional watchdog, enabled by defining
// RST_SEQ_WDT_EN, adds the wdt_kick/wdt_cause ports and the WDT_TIMEOUT_US
// parameter, and starts a sequence itself when it is not serviced in IDLE.
module rst_seq_gen #(
  parameter int unsigned IN_FREQ_KHZ    = 16000,
  parameter int unsigned HOLD_TIME_US   = 50_000,
  parameter int unsigned STAGE_GAP_US   = 10,
  parameter int unsigned NUM_STAGES     = 3
`ifdef RST_SEQ_WDT_EN
  ,
  parameter int unsigned WDT_TIMEOUT_US = 100_000
`endif
) (
  input  logic                  clkin,
  input  logic                  rst,
  input  logic                  req,
  output logic [NUM_STAGES-1:0] rst_out_n,
  output logic                  busy,
  output logic                  done
`ifdef RST_SEQ_WDT_EN
  ,
  input  logic                  wdt_kick,
  output logic                  wdt_cause
`endif
);

  localparam int unsigned CYC_PER_US = IN_FREQ_KHZ / 1000;
  localparam int unsigned HOLD_RAW   = CYC_PER_US * HOLD_TIME_US;
  localparam int unsigned GAP_RAW    = CYC_PER_US * STAGE_GAP_US;
  localparam int unsigned HOLD_CYC   = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
  localparam int unsigned GAP_CYC    = (GAP_RAW < 1) ? 1 : GAP_RAW;
  localparam int unsigned CNT_MAX    = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned CNT_W      = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [NUM_STAGES-1:0]   rel_next;
  logic                    start_seq;

  // Stages release as a growing run of ones from bit 0; the last release is
  // the one that makes the vector all ones, which also covers NUM_STAGES=1.
  always_comb begin
    rel_next = (rst_out_n << 1) | NUM_STAGES'(1);
  end

`ifdef RST_SEQ_WDT_EN
  localparam int unsigned WDT_RAW  = CYC_PER_US * WDT_TIMEOUT_US;
  localparam int unsigned WDT_CYC  = (WDT_RAW < 1) ? 1 : WDT_RAW;
  localparam int unsigned WDT_W    = ($clog2(WDT_CYC) < 1) ? 1 : $clog2(WDT_CYC);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYC - 1);

  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_fire;

  // Expiry only counts in IDLE; a kick or a req on the same cycle takes precedence.
  always_comb begin
    wdt_fire = (state == ST_IDLE) && !req && !wdt_kick && (wdt_cnt == WDT_LAST);
  end

  // Watchdog counter and sticky cause flag.
  always_ff @(posedge clkin) begin
    if (rst) begin
      wdt_cnt   <= '0;
      wdt_cause <= 1'b0;
    end else if (state != ST_IDLE) begin
      wdt_cnt <= '0;
    end else if (req) begin
      wdt_cnt   <= '0;
      wdt_cause <= 1'b0;
    end else if (wdt_kick) begin
      wdt_cnt <= '0;
    end else if (wdt_cnt == WDT_LAST) begin
      wdt_cnt   <= '0;
      wdt_cause <= 1'b1;
    end else begin
      wdt_cnt <= wdt_cnt + WDT_W'(1);
    end
  end

  always_comb begin
    start_seq = req | wdt_fire;
  end
`else
  always_comb begin
    start_seq = req;
  end
`endif

  // Sequencer: hold, staged release, idle; all outputs registered here.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      rst_out_n <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_seq) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            rst_out_n <= '0;
            busy      <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (req) begin
            cnt <= '0;
          end else if (cnt == HOLD_LAST) begin
            cnt       <= '0;
            rst_out_n <= rel_next;
            if (&rel_next) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (req) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            rst_out_n <= '0;
          end else if (cnt == GAP_LAST) begin
            cnt       <= '0;
            rst_out_n <= rel_next;
            if (&rel_next) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= ST_HOLD;
          cnt       <= '0;
          rst_out_n <= '0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule
